// File: rtl/seq_pattern_pkg.sv
// Shared definitions for the serial pattern detector.
// Contents:
//   PAT_LEN_MAX - largest supported pattern length
//   pat_t       - pattern word at the maximum length
//   fill_width  - width of the fill counter for a given pattern length
package seq_pattern_pkg;

   localparam int unsigned PAT_LEN_MAX = 32;

   typedef logic [PAT_LEN_MAX-1:0] pat_t;

   // The fill counter must represent 0..len inclusive.
   function automatic int unsigned fill_width(input int unsigned len);
      return $clog2(len + 1);
   endfunction

endpackage

// File: rtl/seq_pattern_detector_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Ports:
//   clk - clock
//   rst - synchronous active-high reset
//   clr - clear the count
//   inc - count one event
//   cnt - current count
//   sat - count is all-ones
// When clr and inc arrive together, the clear applies first and the event is counted.
module sat_counter
   import seq_pattern_pkg::*;
#(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] cnt,
   output logic         sat
);

   logic [W-1:0] cnt_q, cnt_d, cnt_base;

   always_comb begin
      cnt_base = clr ? '0 : cnt_q;
      cnt_d    = cnt_base;
      if (inc && (cnt_base != '1)) begin
         cnt_d = cnt_base + W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt = cnt_q;
   assign sat = (cnt_q == '1);

endmodule

// File: rtl/seq_pattern_detector.sv
// Serial pattern detector with a runtime-programmable pattern.
// One bit is accepted per in_valid cycle; the first received bit lines up with the pattern MSB.
// Ports:
//   clk, rst     - clock, synchronous active-high reset
//   in_valid     - in_bit is accepted this cycle
//   in_bit       - serial data bit
//   overlap      - 1: overlapping detection, 0: restart after each hit
//   cfg_we       - load cfg_pattern, clear history (the in_bit of this cycle is dropped)
//   cfg_pattern  - new pattern
//   cnt_clr      - clear the match counter
//   match        - registered one-cycle pulse per detection
//   fill         - number of valid history bits, 0..PAT_LEN
//   match_cnt    - saturating detection count
//   cnt_sat      - match_cnt is all-ones
// Build option: define PATDET_MATCH_COUNT_EN to include the match counter; otherwise
// match_cnt and cnt_sat read 0 and cnt_clr is ignored.
module seq_pattern_detector
   import seq_pattern_pkg::*;
#(
   parameter int unsigned        PAT_LEN     = 5,
   parameter logic [PAT_LEN-1:0] RST_PATTERN = 5'b11011,
   parameter int unsigned        CNT_W       = 8
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            in_valid,
   input  logic                            in_bit,
   input  logic                            overlap,
   input  logic                            cfg_we,
   input  logic [PAT_LEN-1:0]              cfg_pattern,
   input  logic                            cnt_clr,
   output logic                            match,
   output logic [fill_width(PAT_LEN)-1:0]  fill,
   output logic [CNT_W-1:0]                match_cnt,
   output logic                            cnt_sat
);

   localparam int unsigned     FillW    = fill_width(PAT_LEN);
   localparam logic [FillW-1:0] FillFull = FillW'(PAT_LEN);

   logic [PAT_LEN-1:0] hist_q, hist_d, hist_shift;
   logic [PAT_LEN-1:0] pat_q, pat_d;
   logic [FillW-1:0]   fill_q, fill_d, fill_inc;
   logic               match_q, match_d;
   logic               hit;

   always_comb begin
      hist_shift = {hist_q[PAT_LEN-2:0], in_bit};
      fill_inc   = (fill_q == FillFull) ? fill_q : fill_q + FillW'(1);
      // A hit needs a full window of bits received since the last restart.
      hit        = in_valid && !cfg_we && (hist_shift == pat_q) && (fill_inc == FillFull);

      hist_d  = hist_q;
      fill_d  = fill_q;
      pat_d   = pat_q;
      match_d = 1'b0;

      if (cfg_we) begin
         pat_d  = cfg_pattern;
         hist_d = '0;
         fill_d = '0;
      end else if (in_valid) begin
         hist_d  = hist_shift;
         // Non-overlapping mode restarts the window; history keeps shifting.
         fill_d  = (hit && !overlap) ? '0 : fill_inc;
         match_d = hit;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hist_q  <= '0;
         fill_q  <= '0;
         pat_q   <= RST_PATTERN;
         match_q <= 1'b0;
      end else begin
         hist_q  <= hist_d;
         fill_q  <= fill_d;
         pat_q   <= pat_d;
         match_q <= match_d;
      end
   end

   assign match = match_q;
   assign fill  = fill_q;

`ifdef PATDET_MATCH_COUNT_EN
   sat_counter #(
      .W (CNT_W)
   ) u_sat_counter (
      .clk (clk),
      .rst (rst),
      .clr (cnt_clr),
      .inc (hit),
      .cnt (match_cnt),
      .sat (cnt_sat)
   );
`else
   logic unused_cnt_clr;
   assign unused_cnt_clr = cnt_clr;
   assign match_cnt      = '0;
   assign cnt_sat        = 1'b0;
`endif

endmodule

// File: tb/tb_seq_pattern_detector.sv
// Bench for seq_pattern_detector: two instances share the stimulus.
//   dut_a: PAT_LEN=5, pattern 11011, CNT_W=8
//   dut_b: PAT_LEN=2, pattern 11,    CNT_W=2 (exercises counter saturation)
// A stream-level model predicts every output each cycle; directed checks pin key results.
module tb_seq_pattern_detector;

`ifdef PATDET_MATCH_COUNT_EN
   localparam bit CntEn = 1'b1;
`else
   localparam bit CntEn = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_bit = 1'b0;
   logic       overlap = 1'b0;
   logic       cfg_we = 1'b0;
   logic       cnt_clr = 1'b0;
   logic [4:0] cfg_pat_a = 5'b0;
   logic [1:0] cfg_pat_b = 2'b11;

   logic       match_a, sat_a;
   logic [2:0] fill_a;
   logic [7:0] cnt_a;
   logic       match_b, sat_b;
   logic [1:0] fill_b;
   logic [1:0] cnt_b;

   int checks = 0;
   int failures = 0;
   bit cmp_en = 1'b0;

   always #5 clk = ~clk;

   seq_pattern_detector #(
      .PAT_LEN     (5),
      .RST_PATTERN (5'b11011),
      .CNT_W       (8)
   ) dut_a (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_bit      (in_bit),
      .overlap     (overlap),
      .cfg_we      (cfg_we),
      .cfg_pattern (cfg_pat_a),
      .cnt_clr     (cnt_clr),
      .match       (match_a),
      .fill        (fill_a),
      .match_cnt   (cnt_a),
      .cnt_sat     (sat_a)
   );

   seq_pattern_detector #(
      .PAT_LEN     (2),
      .RST_PATTERN (2'b11),
      .CNT_W       (2)
   ) dut_b (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_bit      (in_bit),
      .overlap     (overlap),
      .cfg_we      (cfg_we),
      .cfg_pattern (cfg_pat_b),
      .cnt_clr     (cnt_clr),
      .match       (match_b),
      .fill        (fill_b),
      .match_cnt   (cnt_b),
      .cnt_sat     (sat_b)
   );

   // Model: count of bits since the last restart plus the most recent bits.
   typedef struct {
      int unsigned len;
      int unsigned cntw;
      logic [31:0] rst_pat;
      logic [31:0] pat;
      int unsigned nbits;
      logic [31:0] recent;
      int unsigned cnt;
      logic        match;
   } model_t;

   model_t m [2];

   function automatic model_t step(input model_t s, input logic [31:0] cp);
      model_t      n;
      logic [31:0] mask;
      int unsigned cmax;
      bit          hit;
      n     = s;
      hit   = 1'b0;
      mask  = (s.len >= 32) ? 32'hffff_ffff : ((32'd1 << s.len) - 32'd1);
      cmax  = (1 << s.cntw) - 1;
      n.match = 1'b0;
      if (rst) begin
         n.pat    = s.rst_pat;
         n.nbits  = 0;
         n.recent = '0;
         n.cnt    = 0;
         return n;
      end
      if (cfg_we) begin
         n.pat    = cp & mask;
         n.nbits  = 0;
         n.recent = '0;
      end else if (in_valid) begin
         n.recent = {s.recent[30:0], in_bit};
         n.nbits  = s.nbits + 1;
         hit = (n.nbits >= s.len) && ((n.recent & mask) == s.pat);
         if (hit) begin
            n.match = 1'b1;
            if (!overlap) n.nbits = 0;
         end
      end
      if (CntEn) begin
         if (cnt_clr) n.cnt = 0;
         if (hit && n.cnt != cmax) n.cnt = n.cnt + 1;
      end
      return n;
   endfunction

   function automatic int fill_of(input model_t s);
      return (s.nbits >= s.len) ? int'(s.len) : int'(s.nbits);
   endfunction

   function automatic int sat_of(input model_t s);
      return (CntEn && s.cnt == (1 << s.cntw) - 1) ? 1 : 0;
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s at %0t: got=%0h expected=%0h", name, $time, got, exp);
      end
   endtask

   // Per-cycle comparison of both instances against the model.
   always @(negedge clk) begin
      if (cmp_en) begin
         check("a_match", 32'(match_a), 32'(m[0].match));
         check("a_fill",  32'(fill_a),  fill_of(m[0]));
         check("a_cnt",   32'(cnt_a),   m[0].cnt);
         check("a_sat",   32'(sat_a),   sat_of(m[0]));
         check("b_match", 32'(match_b), 32'(m[1].match));
         check("b_fill",  32'(fill_b),  fill_of(m[1]));
         check("b_cnt",   32'(cnt_b),   m[1].cnt);
         check("b_sat",   32'(sat_b),   sat_of(m[1]));
      end
   end

   task automatic tick();
      model_t nx0, nx1;
      nx0 = step(m[0], {27'b0, cfg_pat_a});
      nx1 = step(m[1], {30'b0, cfg_pat_b});
      @(posedge clk);
      m[0]   = nx0;
      m[1]   = nx1;
      cmp_en = 1'b1;
      @(negedge clk);
      #1;
   endtask

   task automatic send(input logic b);
      in_valid = 1'b1;
      in_bit   = b;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   function automatic int cexp(input int n);
      return CntEn ? n : 0;
   endfunction

   initial begin
      logic [7:0] stream;
      logic [7:0] exp_on;
      logic [7:0] exp_off;
      logic [4:0] gap_bits;
      logic [4:0] cfg_bits;

      m[0] = '{len: 5, cntw: 8, rst_pat: 32'b11011, pat: 32'b11011,
               nbits: 0, recent: '0, cnt: 0, match: 1'b0};
      m[1] = '{len: 2, cntw: 2, rst_pat: 32'b11, pat: 32'b11,
               nbits: 0, recent: '0, cnt: 0, match: 1'b0};
      #2;

      // Reset with in_valid high, then idle.
      rst = 1'b1; in_valid = 1'b1; in_bit = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("rst_match", 32'(match_a), 0);
         check("rst_fill",  32'(fill_a),  0);
         check("rst_cnt",   32'(cnt_a),   0);
      end
      rst = 1'b0;
      idle(5);
      check("idle_fill", 32'(fill_a), 0);
      check("idle_match", 32'(match_a), 0);

      // Overlapping detection on 11011011.
      stream  = 8'b11011011;
      exp_on  = 8'b00001001;
      exp_off = 8'b00001000;
      overlap = 1'b1;
      for (int i = 7; i >= 0; i--) begin
         send(stream[i]);
         check("ov_on_match", 32'(match_a), 32'(exp_on[i]));
      end
      check("ov_on_fill", 32'(fill_a), 5);
      check("ov_on_cnt",  32'(cnt_a), cexp(2));

      // Non-overlapping detection on the same stream.
      do_reset();
      overlap = 1'b0;
      for (int i = 7; i >= 0; i--) begin
         send(stream[i]);
         check("ov_off_match", 32'(match_a), 32'(exp_off[i]));
      end
      check("ov_off_fill", 32'(fill_a), 3);
      check("ov_off_cnt",  32'(cnt_a), cexp(1));

      // Valid gaps between bits.
      do_reset();
      overlap  = 1'b1;
      gap_bits = 5'b11011;
      for (int i = 4; i >= 0; i--) begin
         send(gap_bits[i]);
         check("gap_match", 32'(match_a), (i == 0) ? 1 : 0);
         idle(2);
         check("gap_idle_match", 32'(match_a), 0);
      end
      check("gap_cnt", 32'(cnt_a), cexp(1));

      // Same, with a reset after the 4th bit.
      do_reset();
      for (int i = 4; i >= 1; i--) begin
         send(gap_bits[i]);
         idle(2);
      end
      do_reset();
      check("mid_rst_fill",  32'(fill_a), 0);
      check("mid_rst_match", 32'(match_a), 0);
      check("mid_rst_cnt",   32'(cnt_a), 0);
      check("mid_rst_sat",   32'(sat_a), 0);
      send(gap_bits[0]);
      check("mid_rst_nohit", 32'(match_a), 0);
      check("mid_rst_fill1", 32'(fill_a), 1);

      // Build up one count, then reconfigure while a bit is offered.
      for (int i = 4; i >= 0; i--) send(gap_bits[i]);
      check("pre_cfg_cnt", 32'(cnt_a), cexp(1));
      cfg_pat_a = 5'b10101;
      cfg_we    = 1'b1;
      in_valid  = 1'b1;
      in_bit    = 1'b1;
      tick();
      cfg_we   = 1'b0;
      in_valid = 1'b0;
      check("cfg_fill",  32'(fill_a), 0);
      check("cfg_match", 32'(match_a), 0);
      check("cfg_cnt",   32'(cnt_a), cexp(1));
      cfg_bits = 5'b10101;
      for (int i = 4; i >= 0; i--) begin
         send(cfg_bits[i]);
         check("cfg_stream_match", 32'(match_a), (i == 0) ? 1 : 0);
      end
      check("cfg_post_cnt", 32'(cnt_a), cexp(2));

      // Saturation on the narrow-counter instance.
      do_reset();
      overlap = 1'b1;
      for (int i = 0; i < 10; i++) send(1'b1);
      check("sat_cnt", 32'(cnt_b), cexp(3));
      check("sat_flag", 32'(sat_b), CntEn ? 1 : 0);
      check("sat_match", 32'(match_b), 1);
      cnt_clr = 1'b1;
      send(1'b1);
      cnt_clr = 1'b0;
      check("clr_hit_cnt", 32'(cnt_b), cexp(1));
      check("clr_hit_sat", 32'(sat_b), 0);
      cnt_clr = 1'b1;
      tick();
      cnt_clr = 1'b0;
      check("clr_only_cnt", 32'(cnt_b), 0);
      idle(2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
